// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - W-stage write-back mux, 31x32 GPR file with write-through bypass, retire counter (optional sub-word loads: WB_LOAD_EXT_EN)
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        WBValid_W,
    input  logic        RegWrite_W,
    input  logic [4:0]  WriteReg_W,
    input  logic [1:0]  WBSel_W,
    input  logic [2:0]  LoadType_W,
    input  logic [31:0] DMout_W,
    input  logic [31:0] AO_W,
    input  logic [31:0] PCAdd8_W,
    input  logic [4:0]  RA1_D,
    input  logic [4:0]  RA2_D,
    output logic [31:0] RD1_D,
    output logic [31:0] RD2_D,
    output logic [31:0] WD_W,
    output logic [31:0] RetireCnt
);

    localparam logic [2:0] LT_LBU = 3'b001;
    localparam logic [2:0] LT_LB  = 3'b010;
    localparam logic [2:0] LT_LHU = 3'b011;
    localparam logic [2:0] LT_LH  = 3'b100;

    // GPR0 is hard-wired zero, so only 1..31 are stored
    logic [31:0] gpr [1:31] = '{default: '0};
    logic [31:0] retire_cnt_q = '0;
    logic [31:0] load_data;
    logic        we;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Pick the addressed little-endian lane, then extend per load type
    always_comb begin
        load_byte = 8'h00;
        case (AO_W[1:0])
            2'b00:   load_byte = DMout_W[7:0];
            2'b01:   load_byte = DMout_W[15:8];
            2'b10:   load_byte = DMout_W[23:16];
            default: load_byte = DMout_W[31:24];
        endcase
        load_half = AO_W[1] ? DMout_W[31:16] : DMout_W[15:0];
        case (LoadType_W)
            LT_LBU:  load_data = {24'h000000, load_byte};
            LT_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            LT_LHU:  load_data = {16'h0000, load_half};
            LT_LH:   load_data = {{16{load_half[15]}}, load_half};
            default: load_data = DMout_W;
        endcase
    end
`else
    logic unused_load_type;
    assign unused_load_type = ^{LoadType_W, LT_LBU, LT_LB, LT_LHU, LT_LH};

    // Full-word loads only: load type has no effect
    always_comb begin
        load_data = DMout_W;
    end
`endif

    // Write-back source select; independent of valid/regwrite so forwarding sees it early
    always_comb begin
        WD_W = '0;
        case (WBSel_W)
            2'b00:   WD_W = AO_W;
            2'b01:   WD_W = load_data;
            2'b10:   WD_W = PCAdd8_W;
            default: WD_W = '0;
        endcase
    end

    // Bubbles and writes to GPR0 never commit; reset discards the write on its edge
    always_comb begin
        we = WBValid_W & RegWrite_W & (WriteReg_W != 5'd0) & ~reset;
    end

    // Read port 1: zero register, then same-cycle write-through, then storage
    always_comb begin
        RD1_D = '0;
        if (RA1_D == 5'd0)
            RD1_D = '0;
        else if (we && (RA1_D == WriteReg_W))
            RD1_D = WD_W;
        else
            RD1_D = gpr[RA1_D];
    end

    // Read port 2: same priority as port 1, bypassed independently
    always_comb begin
        RD2_D = '0;
        if (RA2_D == 5'd0)
            RD2_D = '0;
        else if (we && (RA2_D == WriteReg_W))
            RD2_D = WD_W;
        else
            RD2_D = gpr[RA2_D];
    end

    // Register file update: clear everything on reset, else commit one write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++)
                gpr[i] <= '0;
        end else if (we) begin
            gpr[WriteReg_W] <= WD_W;
        end
    end

    // Count every non-bubble instruction leaving W; wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset)
            retire_cnt_q <= '0;
        else if (WBValid_W)
            retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    assign RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - table-driven self-checking bench for wb_regfile
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        WBValid_W;
    logic        RegWrite_W;
    logic [4:0]  WriteReg_W;
    logic [1:0]  WBSel_W;
    logic [2:0]  LoadType_W;
    logic [31:0] DMout_W;
    logic [31:0] AO_W;
    logic [31:0] PCAdd8_W;
    logic [4:0]  RA1_D;
    logic [4:0]  RA2_D;
    logic [31:0] RD1_D;
    logic [31:0] RD2_D;
    logic [31:0] WD_W;
    logic [31:0] RetireCnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .WBValid_W  (WBValid_W),
        .RegWrite_W (RegWrite_W),
        .WriteReg_W (WriteReg_W),
        .WBSel_W    (WBSel_W),
        .LoadType_W (LoadType_W),
        .DMout_W    (DMout_W),
        .AO_W       (AO_W),
        .PCAdd8_W   (PCAdd8_W),
        .RA1_D      (RA1_D),
        .RA2_D      (RA2_D),
        .RD1_D      (RD1_D),
        .RD2_D      (RD2_D),
        .WD_W       (WD_W),
        .RetireCnt  (RetireCnt)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic        rw;
        logic [4:0]  wreg;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [31:0] dm;
        logic [31:0] ao;
        logic [31:0] pc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_wd_raw;
        logic [31:0] e_wd_ext;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset      = v.rst;
        WBValid_W  = v.vld;
        RegWrite_W = v.rw;
        WriteReg_W = v.wreg;
        WBSel_W    = v.sel;
        LoadType_W = v.lt;
        DMout_W    = v.dm;
        AO_W       = v.ao;
        PCAdd8_W   = v.pc;
        RA1_D      = v.ra1;
        RA2_D      = v.ra2;
    endtask

    initial begin
        logic [31:0] exp_wd;
        // rst vld rw wreg sel lt dm ao pc ra1 ra2 | rd1 rd2 wd(raw) wd(ext) cnt-before-edge
        vecs[0]  = '{1,0,0,5'd0, 2'b00,3'd0,32'h0,        32'h0,        32'h0,    5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'd0};
        vecs[1]  = '{0,1,1,5'd5, 2'b00,3'd0,32'h0,        32'h12345678, 32'h0,    5'd5, 5'd0,  32'h12345678, 32'h0,        32'h12345678, 32'h12345678, 32'd0};
        vecs[2]  = '{0,0,0,5'd0, 2'b00,3'd0,32'h0,        32'h0,        32'h0,    5'd5, 5'd7,  32'h12345678, 32'h0,        32'h0,        32'h0,        32'd1};
        vecs[3]  = '{0,1,1,5'd0, 2'b00,3'd0,32'h0,        32'hFFFFFFFF, 32'h0,    5'd0, 5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
        vecs[4]  = '{0,0,0,5'd0, 2'b00,3'd0,32'h0,        32'h0,        32'h0,    5'd0, 5'd5,  32'h0,        32'h12345678, 32'h0,        32'h0,        32'd2};
        vecs[5]  = '{0,0,0,5'd0, 2'b01,3'd2,32'h80FF7F01, 32'h1,        32'h0,    5'd0, 5'd0,  32'h0,        32'h0,        32'h80FF7F01, 32'h0000007F, 32'd2};
        vecs[6]  = '{0,0,0,5'd0, 2'b01,3'd2,32'h80FF7F01, 32'h3,        32'h0,    5'd0, 5'd0,  32'h0,        32'h0,        32'h80FF7F01, 32'hFFFFFF80, 32'd2};
        vecs[7]  = '{0,0,0,5'd0, 2'b01,3'd3,32'h80FF7F01, 32'h2,        32'h0,    5'd0, 5'd0,  32'h0,        32'h0,        32'h80FF7F01, 32'h000080FF, 32'd2};
        vecs[8]  = '{0,0,0,5'd0, 2'b01,3'd4,32'h80FF7F01, 32'h3,        32'h0,    5'd0, 5'd0,  32'h0,        32'h0,        32'h80FF7F01, 32'hFFFF80FF, 32'd2};
        vecs[9]  = '{0,0,0,5'd0, 2'b01,3'd1,32'h80FF7F01, 32'h0,        32'h0,    5'd0, 5'd0,  32'h0,        32'h0,        32'h80FF7F01, 32'h00000001, 32'd2};
        vecs[10] = '{0,0,0,5'd0, 2'b01,3'd7,32'h80FF7F01, 32'h2,        32'h0,    5'd0, 5'd0,  32'h0,        32'h0,        32'h80FF7F01, 32'h80FF7F01, 32'd2};
        vecs[11] = '{0,1,1,5'd7, 2'b00,3'd0,32'h0,        32'hA5A5A5A5, 32'h0,    5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd2};
        vecs[12] = '{0,0,1,5'd7, 2'b00,3'd0,32'h0,        32'hDEADBEEF, 32'h0,    5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hDEADBEEF, 32'd3};
        vecs[13] = '{0,0,0,5'd0, 2'b00,3'd0,32'h0,        32'h0,        32'h0,    5'd7, 5'd5,  32'hA5A5A5A5, 32'h12345678, 32'h0,        32'h0,        32'd3};
        vecs[14] = '{0,1,0,5'd7, 2'b00,3'd0,32'h0,        32'h11111111, 32'h0,    5'd7, 5'd0,  32'hA5A5A5A5, 32'h0,        32'h11111111, 32'h11111111, 32'd3};
        vecs[15] = '{0,1,1,5'd31,2'b10,3'd0,32'h0,        32'h0,        32'h3008, 5'd31,5'd0,  32'h00003008, 32'h0,        32'h00003008, 32'h00003008, 32'd4};
        vecs[16] = '{0,0,0,5'd0, 2'b11,3'd0,32'h0,        32'hFFFF,     32'h3008, 5'd31,5'd0,  32'h00003008, 32'h0,        32'h0,        32'h0,        32'd5};
        vecs[17] = '{0,1,1,5'd3, 2'b00,3'd0,32'h0,        32'h33,       32'h0,    5'd3, 5'd0,  32'h33,       32'h0,        32'h33,       32'h33,       32'd5};
        vecs[18] = '{0,0,0,5'd0, 2'b00,3'd0,32'h0,        32'h0,        32'h0,    5'd3, 5'd31, 32'h33,       32'h00003008, 32'h0,        32'h0,        32'd6};
        vecs[19] = '{1,1,1,5'd3, 2'b00,3'd0,32'h0,        32'h77,       32'h0,    5'd3, 5'd31, 32'h33,       32'h00003008, 32'h77,       32'h77,       32'd6};
        vecs[20] = '{0,0,0,5'd0, 2'b00,3'd0,32'h0,        32'h0,        32'h0,    5'd3, 5'd31, 32'h0,        32'h0,        32'h0,        32'h0,        32'd0};
        vecs[21] = '{0,1,1,5'd3, 2'b00,3'd0,32'h0,        32'h55,       32'h0,    5'd3, 5'd0,  32'h55,       32'h0,        32'h55,       32'h55,       32'd0};
        vecs[22] = '{0,0,0,5'd0, 2'b00,3'd0,32'h0,        32'h0,        32'h0,    5'd3, 5'd7,  32'h55,       32'h0,        32'h0,        32'h0,        32'd1};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
`ifdef WB_LOAD_EXT_EN
            exp_wd = vecs[i].e_wd_ext;
`else
            exp_wd = vecs[i].e_wd_raw;
`endif
            check("rd1", i, RD1_D, vecs[i].e_rd1);
            check("rd2", i, RD2_D, vecs[i].e_rd2);
            check("wd", i, WD_W, exp_wd);
            check("retire_cnt", i, RetireCnt, vecs[i].e_cnt);
            @(posedge clk);
            @(negedge clk);
        end

        // Counter wrap: preload all-ones while idle, then retire one instruction
        WBValid_W  = 1'b0;
        RegWrite_W = 1'b0;
        dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        check("cnt_preload", 100, RetireCnt, 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        check("cnt_hold_bubble", 101, RetireCnt, 32'hFFFF_FFFF);
        WBValid_W = 1'b1;
        @(posedge clk);
        @(negedge clk);
        WBValid_W = 1'b0;
        #1;
        check("cnt_wrap", 102, RetireCnt, 32'h0);
        RA1_D = 5'd3;
        RA2_D = 5'd31;
        #1;
        check("gpr3_after_wrap", 103, RD1_D, 32'h55);
        check("gpr31_after_reset", 104, RD2_D, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 WBValid_W  input  1  W stage holds a real instruction (0 = bubble).
REQ-005 RegWrite_W  input  1  instruction in W writes a GPR.
REQ-006 WriteReg_W  input  5  destination GPR index.
REQ-007 WBSel_W  input  2  write-data source: 00 AO_W, 01 load data, 10 PCAdd8_W, 11 constant 0.
REQ-008 LoadType_W  input  3  000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; 101-111 treated as lw.
REQ-009 DMout_W  input  32  raw data-memory word from the MEM/WB register.
REQ-010 AO_W  input  32  ALU result / memory address from the MEM/WB register.
REQ-011 PCAdd8_W  input  32  link address from the MEM/WB register.
REQ-012 RA1_D, RA2_D  input  5 each  decode-stage read addresses.
REQ-013 RD1_D, RD2_D  output  32 each  decode-stage read data.
REQ-014 WD_W  output  32  final write-back data, exported for forwarding.
REQ-015 RetireCnt  output  32  count of retired (non-bubble) W-stage instructions.

Function
REQ-016 Storage SHALL be 31 x 32-bit registers for GPR 1-31; GPR 0 SHALL always read 0 and never be stored.
REQ-017 Load data SHALL be little-endian: byte lane = AO_W[1:0] (lane 0 = DMout_W[7:0]); halfword lane = AO_W[1] (0 = [15:0]); AO_W[0] ignored for halfwords.
REQ-018 lbu/lhu SHALL zero-extend, lb/lh SHALL sign-extend to 32 bits; lw SHALL pass DMout_W unchanged.
REQ-019 WD_W SHALL be combinational from current W inputs per WBSel_W, independent of WBValid_W/RegWrite_W.
REQ-020 Write-enable we = WBValid_W & RegWrite_W & (WriteReg_W != 0) & ~reset; when we=1, GPR[WriteReg_W] SHALL take WD_W at the rising edge (1-cycle write latency).
REQ-021 Read ports SHALL be combinational: address 0 -> 0; else if we=1 and address == WriteReg_W -> WD_W (same-cycle write-through bypass); else stored value.
REQ-022 Both read ports SHALL bypass independently, including RA1_D == RA2_D == WriteReg_W.
REQ-023 RetireCnt SHALL increment by 1 on each rising edge with WBValid_W=1 and reset=0, regardless of RegWrite_W; 0xFFFFFFFF SHALL wrap to 0.
REQ-024 Bubbles (WBValid_W=0) SHALL neither write nor count, and SHALL NOT drive a bypass.

Reset
REQ-025 On a rising edge with reset=1, all GPRs and RetireCnt SHALL become 0; any write or count on that edge SHALL be discarded.
REQ-026 Reset asserted mid-stream SHALL take effect on that edge only; first post-reset edge with we=1 SHALL write normally.
REQ-027 During reset, outputs remain combinational: RD1_D/RD2_D show stored values (no bypass since we=0); WD_W reflects inputs.
REQ-028 Registers SHALL also power up at 0 in simulation.

Configuration
REQ-029 Macro WB_LOAD_EXT_EN: when defined, REQ-017/018 sub-word extraction and extension SHALL be compiled in.
REQ-030 Without WB_LOAD_EXT_EN, LoadType_W SHALL be ignored and load data SHALL equal DMout_W for all load types.

Verification
REQ-031 reset, then write GPR5=0x12345678 (valid, RegWrite, WBSel=00); next cycle RA1_D=5 -> RD1_D=0x12345678, RetireCnt=1.
REQ-032 Write GPR0=0xFFFFFFFF -> RD1_D for RA1_D=0 remains 0; RetireCnt still increments.
REQ-033 DMout_W=0x80FF7F01, AO_W low bits 2'b01, lb -> WD_W=0x0000007F; bits 2'b11 lb -> 0xFFFFFF80; lhu AO_W[1]=1 -> 0x000080FF; without WB_LOAD_EXT_EN all -> 0x80FF7F01.
REQ-034 Same cycle write GPR7=0xA5A5A5A5 with RA1_D=RA2_D=7 -> both reads 0xA5A5A5A5 that cycle; with WBValid_W=0 instead -> old value, no write, no count.
REQ-035 Preload RetireCnt to 0xFFFFFFFF via 2^32-1 valid cycles (or force) then one more valid cycle -> 0; reset asserted same edge as a GPR3 write -> GPR3=0, RetireCnt=0.
REQ-036 WBSel=10, PCAdd8_W=0x00003008, WriteReg_W=31 -> GPR31=0x00003008; WBSel=11 -> WD_W=0.
